fifo_burst_rd_arbiter: RTL and testbench
========================================

Name: fifo_burst_rd_arbiter

Overview:
Multi-channel read-side scheduler between N_CH input FIFOs and the SDRAM write path. It watches each FIFO's fill level and offers one burst at a time to the SDRAM controller, serving channels in round-robin order. Once the SDRAM side accepts a burst, it drives the granted FIFO's rdreq for exactly the burst length. It also supports flush, which drains a partial burst on request.

Parameters:
N_CH, 2, number of FIFO channels (1..8)
USEDW_W, 10, width of each FIFO usedw bus
BURST_LEN, 512, words per full burst; must satisfy 1 <= BURST_LEN <= 2^USEDW_W - 1
CH_W, 1, width of ch_sel; must satisfy 2^CH_W >= N_CH
LEN_W, 10, width of burst_words; must satisfy 2^LEN_W > BURST_LEN

Ports:
clk  in  1  system clock, all logic on the rising edge
rst_n  in  1  asynchronous, active-low reset
usedw  in  N_CH*USEDW_W  packed fill levels; channel k occupies bits [k*USEDW_W +: USEDW_W]
flush  in  N_CH  level per channel; requests draining of a partial burst
sdram_rx_rdy  in  1  SDRAM side accepts the offered burst; sampled only in OFFER
fifo_tx_rdy  out  1  a burst is offered; held high until accepted
ch_sel  out  CH_W  granted channel; valid while fifo_tx_rdy or busy is high
burst_words  out  LEN_W  length of the offered or active burst
rdreq  out  N_CH  one-hot FIFO read enables
busy  out  1  high in OFFER and READ
burst_done  out  1  one-cycle pulse after the last rdreq of a burst

Behaviour:
- Reset (async assert, sync release): FSM goes to IDLE. fifo_tx_rdy, rdreq, busy, burst_done, ch_sel and burst_words are all 0. Round-robin pointer rr = 0. Reset asserted mid-burst drops rdreq immediately. No resume after reset.
- Eligibility of channel k: usedw_k >= BURST_LEN (full burst), or flush[k] = 1 and usedw_k != 0 (partial burst). Full takes precedence over partial.
- IDLE:
  - Scan channels rr, rr+1, …, wrapping modulo N_CH. The first eligible channel is granted.
  - Registered outputs: ch_sel = k. burst_words = BURST_LEN if full, else the usedw_k snapshot.
  - fifo_tx_rdy = 1, busy = 1, go to OFFER.
  - Latency: eligibility sampled at edge n gives fifo_tx_rdy high after edge n.
  - No eligible channel: stay in IDLE with outputs 0.
- OFFER:
  - ch_sel and burst_words stay frozen, even if usedw grows or flush drops.
  - On an edge that samples sdram_rx_rdy = 1: fifo_tx_rdy <= 0, rdreq[ch_sel] <= 1, counter <= 1, go to READ. So rdreq is high in the cycle after acceptance.
  - There is no timeout; OFFER holds indefinitely.
- READ:
  - rdreq[ch_sel] stays high for exactly burst_words consecutive cycles.
  - The counter increments each cycle. When counter == burst_words: rdreq <= 0, burst_done <= 1 for one cycle, busy <= 0, rr <= (ch_sel + 1) mod N_CH, go to IDLE.
  - sdram_rx_rdy is ignored in READ and IDLE.
- Back-to-back bursts: the next grant can be evaluated in the cycle burst_done is high. This gives a minimum gap of 1 cycle between the last rdreq and the next fifo_tx_rdy.
- Invariants: at most one rdreq bit is high at any time. rdreq is never high outside READ. fifo_tx_rdy and rdreq are never high in the same cycle.
- Width rules:
  - The counter is LEN_W bits and never wraps.
  - Comparisons are unsigned.
  - A partial length is usedw_k truncated to LEN_W bits; this is lossless because usedw_k < BURST_LEN < 2^LEN_W.
- N_CH = 1: the round-robin pointer is always 0 and ch_sel is always 0.

Test Plan:
1. N_CH=2, BURST_LEN=512; usedw0 ramps to 512 while usedw1 = 0; sdram_rx_rdy pulses 3 cycles after the offer -> fifo_tx_rdy=1 with ch_sel=0 and burst_words=512; rdreq[0] high exactly 512 cycles starting the cycle after acceptance; burst_done one cycle after the last rdreq; rdreq[1] never high.
2. Both channels hold usedw=600 continuously, sdram_rx_rdy always 1 -> grants alternate 0,1,0,1; 1-cycle gap between bursts; each burst exactly 512 rdreq cycles.
3. usedw1=37 with flush[1]=1, usedw0=0 -> offer ch_sel=1, burst_words=37; rdreq[1] high 37 cycles. Raising usedw1 to 40 during OFFER leaves burst_words at 37.
4. Channel 0 full and channel 1 flush-eligible with rr=0 -> channel 0 granted first, channel 1 next (burst_words = its usedw at grant time).
5. rst_n pulsed low at the 200th rdreq cycle -> all outputs 0 immediately, no further rdreq, rr=0; after release with usedw0 >= 512, a fresh 512-word burst on channel 0.
6. sdram_rx_rdy=1 while in IDLE with no eligible channel, then during READ -> no state change, no extra rdreq cycles.

Source files
------------

// File: rtl/fifo_burst_rd_arbiter.sv
// Round-robin burst read scheduler: picks one eligible FIFO at a time, offers a
// burst to the SDRAM side and, once accepted, drives that FIFO's rdreq for
// exactly burst_words cycles.
module fifo_burst_rd_arbiter #(
   parameter int unsigned N_CH      = 2,
   parameter int unsigned USEDW_W   = 10,
   parameter int unsigned BURST_LEN = 512,
   parameter int unsigned CH_W      = 1,
   parameter int unsigned LEN_W     = 10
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [N_CH*USEDW_W-1:0]   usedw,
   input  logic [N_CH-1:0]           flush,
   input  logic                      sdram_rx_rdy,
   output logic                      fifo_tx_rdy,
   output logic [CH_W-1:0]           ch_sel,
   output logic [LEN_W-1:0]          burst_words,
   output logic [N_CH-1:0]           rdreq,
   output logic                      busy,
   output logic                      burst_done
);

   localparam logic [USEDW_W-1:0] BurstLenU = USEDW_W'(BURST_LEN);
   localparam logic [LEN_W-1:0]   BurstLenL = LEN_W'(BURST_LEN);

   typedef enum logic [1:0] {StIdle, StOffer, StRead} state_e;

   state_e            state_q, state_d;
   logic [CH_W-1:0]   rr_q, rr_d;
   logic [CH_W-1:0]   ch_sel_q, ch_sel_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic [N_CH-1:0]   rdreq_q, rdreq_d;
   logic              tx_q, tx_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic              grant_vld;
   logic [CH_W-1:0]   grant_ch;
   logic [LEN_W-1:0]  grant_len;

   // Scan channels from rr upward (wrapping); first eligible one wins.
   always_comb begin
      grant_vld = 1'b0;
      grant_ch  = '0;
      grant_len = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         int unsigned        idx;
         logic [USEDW_W-1:0] uw;
         logic               full, part;
         idx  = (int'(rr_q) + i) % N_CH;
         uw   = usedw[idx*USEDW_W +: USEDW_W];
         full = (uw >= BurstLenU);
         part = flush[idx] && (uw != '0);
         if (!grant_vld && (full || part)) begin
            grant_vld = 1'b1;
            grant_ch  = CH_W'(idx);
            grant_len = full ? BurstLenL : LEN_W'(uw);
         end
      end
   end

   // Next-state and registered-output logic for the IDLE/OFFER/READ FSM.
   always_comb begin
      state_d  = state_q;
      rr_d     = rr_q;
      ch_sel_d = ch_sel_q;
      len_d    = len_q;
      cnt_d    = cnt_q;
      rdreq_d  = rdreq_q;
      tx_d     = tx_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (grant_vld) begin
               ch_sel_d = grant_ch;
               len_d    = grant_len;
               tx_d     = 1'b1;
               busy_d   = 1'b1;
               state_d  = StOffer;
            end
         end
         StOffer: begin
            // ch_sel/len stay frozen here regardless of usedw or flush changes
            if (sdram_rx_rdy) begin
               tx_d  = 1'b0;
               cnt_d = LEN_W'(1);
               for (int unsigned k = 0; k < N_CH; k++) begin
                  rdreq_d[k] = (CH_W'(k) == ch_sel_q);
               end
               state_d = StRead;
            end
         end
         StRead: begin
            if (cnt_q == len_q) begin
               rdreq_d  = '0;
               done_d   = 1'b1;
               busy_d   = 1'b0;
               rr_d     = CH_W'((int'(ch_sel_q) + 1) % N_CH);
               ch_sel_d = '0;
               len_d    = '0;
               cnt_d    = '0;
               state_d  = StIdle;
            end else begin
               cnt_d = cnt_q + LEN_W'(1);
            end
         end
         default: begin
            state_d = StIdle;
            rdreq_d = '0;
            tx_d    = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers; async reset drops everything, including rdreq.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         rr_q     <= '0;
         ch_sel_q <= '0;
         len_q    <= '0;
         cnt_q    <= '0;
         rdreq_q  <= '0;
         tx_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_q     <= rr_d;
         ch_sel_q <= ch_sel_d;
         len_q    <= len_d;
         cnt_q    <= cnt_d;
         rdreq_q  <= rdreq_d;
         tx_q     <= tx_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign fifo_tx_rdy = tx_q;
   assign ch_sel      = ch_sel_q;
   assign burst_words = len_q;
   assign rdreq       = rdreq_q;
   assign busy        = busy_q;
   assign burst_done  = done_q;

endmodule

// File: tb/tb_fifo_burst_rd_arbiter.sv
// Directed bench for fifo_burst_rd_arbiter (N_CH=2, BURST_LEN=512).
module tb_fifo_burst_rd_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [19:0] usedw;
   logic [1:0]  flush;
   logic        sdram_rx_rdy;
   logic        fifo_tx_rdy;
   logic [0:0]  ch_sel;
   logic [9:0]  burst_words;
   logic [1:0]  rdreq;
   logic        busy;
   logic        burst_done;

   int n_total = 0;
   int n_bad   = 0;
   int rd0_cnt = 0;
   int rd1_cnt = 0;
   int viol    = 0;
   bit rx_hold = 1'b0;

   always #5 clk = ~clk;

   fifo_burst_rd_arbiter #(
      .N_CH(2), .USEDW_W(10), .BURST_LEN(512), .CH_W(1), .LEN_W(10)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .usedw        (usedw),
      .flush        (flush),
      .sdram_rx_rdy (sdram_rx_rdy),
      .fifo_tx_rdy  (fifo_tx_rdy),
      .ch_sel       (ch_sel),
      .burst_words  (burst_words),
      .rdreq        (rdreq),
      .busy         (busy),
      .burst_done   (burst_done)
   );

   // Count rdreq cycles per channel and invariant violations.
   always @(negedge clk) begin
      if (rdreq[0]) rd0_cnt <= rd0_cnt + 1;
      if (rdreq[1]) rd1_cnt <= rd1_cnt + 1;
      if ((rdreq == 2'b11) || ((rdreq != 2'b00) && fifo_tx_rdy) ||
          ((rdreq != 2'b00) && !busy))
         viol <= viol + 1;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   task automatic set_uw(input int ch, input int val);
      usedw[ch*10 +: 10] = 10'(val);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic wait_offer(input string tag, input int ch, input int len);
      int n = 0;
      while (!fifo_tx_rdy && n < 50) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_offer"}, fifo_tx_rdy, 1);
      check({tag, "_ch"}, ch_sel, ch);
      check({tag, "_len"}, burst_words, len);
      check({tag, "_busy"}, busy, 1);
   endtask

   task automatic accept_count(input string tag, input int ch, input int len);
      int n = 0;
      logic [1:0] oh;
      oh = 2'b01 << ch;
      if (!rx_hold) sdram_rx_rdy = 1'b1;
      @(negedge clk);
      if (!rx_hold) sdram_rx_rdy = 1'b0;
      check({tag, "_rdreq1"}, rdreq, oh);
      check({tag, "_txlow"}, fifo_tx_rdy, 0);
      while (rdreq[ch] && n < 1000) begin
         n++;
         @(negedge clk);
      end
      check({tag, "_nrd"}, n, len);
      check({tag, "_done"}, burst_done, 1);
      check({tag, "_busy0"}, busy, 0);
   endtask

   initial begin
      int s0, s1;
      rst_n = 1'b0;
      usedw = '0;
      flush = '0;
      sdram_rx_rdy = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_tx", fifo_tx_rdy, 0);
      check("rst_rdreq", rdreq, 0);
      check("rst_busy", busy, 0);
      check("rst_done", burst_done, 0);
      check("rst_ch", ch_sel, 0);
      check("rst_len", burst_words, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // 1: ramp ch0 to 512, accept 3 cycles after offer
      s1 = rd1_cnt;
      for (int v = 500; v < 512; v++) begin
         set_uw(0, v);
         @(negedge clk);
      end
      check("t1_notyet", fifo_tx_rdy, 0);
      set_uw(0, 512);
      @(negedge clk);
      check("t1_lat", fifo_tx_rdy, 1);
      repeat (3) @(negedge clk);
      wait_offer("t1", 0, 512);
      accept_count("t1", 0, 512);
      set_uw(0, 0);
      repeat (2) @(negedge clk);
      check("t1_rd1", rd1_cnt - s1, 0);

      // 2: both full, rdy held high: 0,1,0,1 with one-cycle gaps
      do_reset();
      set_uw(0, 600);
      set_uw(1, 600);
      rx_hold = 1'b1;
      sdram_rx_rdy = 1'b1;
      for (int b = 0; b < 4; b++) begin
         wait_offer("t2", b % 2, 512);
         accept_count("t2", b % 2, 512);
         if (b < 3) begin
            @(negedge clk);
            check("t2_gap", fifo_tx_rdy, 1);
         end
      end
      set_uw(0, 0);
      set_uw(1, 0);
      sdram_rx_rdy = 1'b0;
      rx_hold = 1'b0;
      repeat (3) @(negedge clk);

      // 3: partial flush on ch1, length frozen in OFFER
      set_uw(1, 37);
      flush = 2'b10;
      wait_offer("t3", 1, 37);
      set_uw(1, 40);
      flush = 2'b00;
      repeat (2) @(negedge clk);
      check("t3_frozen_len", burst_words, 37);
      check("t3_frozen_ch", ch_sel, 1);
      accept_count("t3", 1, 37);
      set_uw(1, 0);
      repeat (2) @(negedge clk);

      // 4: full beats partial from rr=0; partial length snapshotted at grant
      do_reset();
      set_uw(0, 600);
      set_uw(1, 20);
      flush = 2'b10;
      wait_offer("t4a", 0, 512);
      set_uw(1, 25);
      accept_count("t4a", 0, 512);
      set_uw(0, 0);
      wait_offer("t4b", 1, 25);
      accept_count("t4b", 1, 25);
      set_uw(1, 0);
      flush = 2'b00;
      repeat (2) @(negedge clk);

      // 5: reset at the 200th rdreq of a ch1 burst, then fresh ch0 burst
      set_uw(0, 600);
      set_uw(1, 600);
      wait_offer("t5a", 0, 512);
      accept_count("t5a", 0, 512);
      wait_offer("t5b", 1, 512);
      sdram_rx_rdy = 1'b1;
      @(negedge clk);
      sdram_rx_rdy = 1'b0;
      for (int i = 1; i < 200; i++) @(negedge clk);
      check("t5_200th", rdreq, 2'b10);
      rst_n = 1'b0;
      #1;
      check("t5_rst_rdreq", rdreq, 0);
      check("t5_rst_tx", fifo_tx_rdy, 0);
      check("t5_rst_busy", busy, 0);
      check("t5_rst_ch", ch_sel, 0);
      check("t5_rst_len", burst_words, 0);
      repeat (2) @(negedge clk);
      check("t5_hold_rdreq", rdreq, 0);
      rst_n = 1'b1;
      wait_offer("t5c", 0, 512);
      set_uw(0, 0);
      set_uw(1, 0);
      accept_count("t5c", 0, 512);
      repeat (2) @(negedge clk);

      // 6: rdy ignored in IDLE and READ
      sdram_rx_rdy = 1'b1;
      repeat (5) @(negedge clk);
      check("t6_idle_tx", fifo_tx_rdy, 0);
      check("t6_idle_busy", busy, 0);
      check("t6_idle_rdreq", rdreq, 0);
      sdram_rx_rdy = 1'b0;
      s0 = rd0_cnt;
      set_uw(0, 600);
      wait_offer("t6", 0, 512);
      set_uw(0, 0);
      rx_hold = 1'b1;
      sdram_rx_rdy = 1'b1;
      accept_count("t6", 0, 512);
      repeat (3) @(negedge clk);
      check("t6_no_reoffer", fifo_tx_rdy, 0);
      sdram_rx_rdy = 1'b0;
      rx_hold = 1'b0;
      @(negedge clk);
      check("t6_rd0_total", rd0_cnt - s0, 512);

      check("invariants", viol, 0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
